// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES key-schedule engine.
// KEY_EXP_ZEROIZE_EN adds the ZERO state to state_t.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    READY
`ifdef KEY_EXP_ZEROIZE_EN
    , ZERO
`endif
  } state_t;

  localparam logic [7:0] RCON_INIT = 8'h01;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic int nk_of(input int kb);
    return kb / 32;
  endfunction

  function automatic int nr_of(input int kb);
    return kb / 32 + 6;
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// AES SubWord: four combinational S-boxes, 32b in -> 32b out.
// Ports: din (word in), dout (byte-wise S-box of din).
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse as b^254 (maps 0 to 0), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] r;
    p = b;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
             ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    assign dout[8*g +: 8] = sbox(din[8*g +: 8]);
  end

endmodule

// File: rtl/aes_key_expander.sv
// Sequential AES-128/192/256 key schedule, one word per clock.
// Ports: clk, rst_n, key_in/key_valid/key_ready (key load),
// sched_valid, rk_rd_en/rk_rd_idx -> rk_out/rk_out_valid/
// rk_rd_err (1-cycle round-key read). KEY_EXP_ZEROIZE_EN
// adds the zeroize input and the ZERO clearing state.
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef KEY_EXP_ZEROIZE_EN
  input  logic                zeroize,
`endif
  input  logic [KEY_BITS-1:0] key_in,
  input  logic                key_valid,
  output logic                key_ready,
  output logic                sched_valid,
  input  logic                rk_rd_en,
  input  logic [3:0]          rk_rd_idx,
  output logic [127:0]        rk_out,
  output logic                rk_out_valid,
  output logic                rk_rd_err
);

  localparam int NK = nk_of(KEY_BITS);
  localparam int NR = nr_of(KEY_BITS);
  localparam int NW = 4 * (NR + 1);

  if (KEY_BITS != 128 && KEY_BITS != 192
      && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_key_expander: KEY_BITS must be 128/192/256");
  end

  state_t      state;
  state_t      state_n;
  logic [31:0] w [NW];
  logic [5:0]  i;
  logic [2:0]  ph;
  logic [7:0]  rcon;
`ifdef KEY_EXP_ZEROIZE_EN
  logic [3:0]  zc;
`endif
  logic        accept;
  logic        last;
  logic [31:0] prev;
  logic [31:0] sw_in;
  logic [31:0] sw_out;
  logic [31:0] t;
  logic [5:0]  base;

  assign key_ready = (state == IDLE) || (state == READY);
`ifdef KEY_EXP_ZEROIZE_EN
  assign accept = key_valid && key_ready && !zeroize;
`else
  assign accept = key_valid && key_ready;
`endif
  assign last  = (i == 6'(NW - 1));
  assign prev  = w[i - 6'd1];
  // ph tracks i % NK so no divider is needed.
  assign sw_in = (ph == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
  assign base  = {rk_rd_idx, 2'b00};

  aes_sub_word u_sub (
    .din  (sw_in),
    .dout (sw_out)
  );

  always_comb begin
    t = prev;
    if (ph == 3'd0) t = sw_out ^ {rcon, 24'h0};
    else if (NK == 8 && ph == 3'd4) t = sw_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, READY: if (accept) state_n = EXPAND;
      EXPAND:      if (last)   state_n = READY;
`ifdef KEY_EXP_ZEROIZE_EN
      ZERO:        if (zc == 4'(NR)) state_n = IDLE;
`endif
      default:     state_n = IDLE;
    endcase
`ifdef KEY_EXP_ZEROIZE_EN
    if (zeroize) state_n = ZERO;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NW; k++) w[k] <= '0;
      i           <= '0;
      ph          <= '0;
      rcon        <= RCON_INIT;
      sched_valid <= 1'b0;
`ifdef KEY_EXP_ZEROIZE_EN
      zc          <= '0;
`endif
    end else begin
`ifdef KEY_EXP_ZEROIZE_EN
      // Entry edge clears group 0, so a held zeroize restarts there.
      if (zeroize) begin
        for (int k = 0; k < 4; k++) w[k] <= '0;
        zc          <= 4'd1;
        sched_valid <= 1'b0;
      end else if (state == ZERO) begin
        for (int k = 0; k < 4; k++) w[{zc, 2'b00} + 6'(k)] <= '0;
        zc <= zc + 4'd1;
      end else
`endif
      if (accept) begin
        for (int k = 0; k < NK; k++)
          w[k] <= key_in[KEY_BITS-1-32*k -: 32];
        i           <= 6'(NK);
        ph          <= '0;
        rcon        <= RCON_INIT;
        sched_valid <= 1'b0;
      end else if (state == EXPAND) begin
        w[i] <= w[i - 6'(NK)] ^ t;
        i    <= i + 6'd1;
        ph   <= (ph == 3'(NK - 1)) ? 3'd0 : ph + 3'd1;
        if (ph == 3'd0) rcon <= xtime(rcon);
        if (last) sched_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_out       <= '0;
      rk_out_valid <= 1'b0;
      rk_rd_err    <= 1'b0;
    end else if (rk_rd_en && sched_valid) begin
      rk_out_valid <= 1'b1;
      if (rk_rd_idx > 4'(NR)) begin
        rk_out    <= '0;
        rk_rd_err <= 1'b1;
      end else begin
        rk_out    <= {w[base], w[base + 6'd1],
                      w[base + 6'd2], w[base + 6'd3]};
        rk_rd_err <= 1'b0;
      end
    end else begin
      rk_out_valid <= 1'b0;
      rk_rd_err    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aes_key_expander.sv
// Scoreboard bench for aes_key_expander at 128/192/256 bits.
// Honours KEY_EXP_ZEROIZE_EN for the zeroize port and test.
module tb_aes_key_expander;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [255:0] key_in [3];
  logic [2:0]   key_valid;
  logic [2:0]   key_ready;
  logic [2:0]   sched_valid;
  logic [2:0]   rk_rd_en;
  logic [3:0]   rk_rd_idx [3];
  logic [127:0] rk_out [3];
  logic [2:0]   rk_out_valid;
  logic [2:0]   rk_rd_err;
`ifdef KEY_EXP_ZEROIZE_EN
  logic [2:0]   zeroize;
`endif

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int KB = 128 + 64 * g;
    aes_key_expander #(.KEY_BITS(KB)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
`ifdef KEY_EXP_ZEROIZE_EN
      .zeroize      (zeroize[g]),
`endif
      .key_in       (key_in[g][KB-1:0]),
      .key_valid    (key_valid[g]),
      .key_ready    (key_ready[g]),
      .sched_valid  (sched_valid[g]),
      .rk_rd_en     (rk_rd_en[g]),
      .rk_rd_idx    (rk_rd_idx[g]),
      .rk_out       (rk_out[g]),
      .rk_out_valid (rk_out_valid[g]),
      .rk_rd_err    (rk_rd_err[g])
    );
  end

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0]   sbox_t [256];
  logic [31:0]  ref_w [3][60];
  logic [2:0]   mready;
  logic [130:0] sb [$];

  task automatic check(string nm, logic [255:0] act,
                       logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_b(string nm, logic act, logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  // Plain polynomial product, then reduction mod x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int k = 0; k < 8; k++)
      if (b[k]) p = p ^ (16'(a) << k);
    for (int k = 14; k >= 8; k--)
      if (p[k]) p = p ^ (16'h011b << (k - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] c;
    logic [7:0] s;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int b = 0; b < 8; b++)
        s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8]
             ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [31:0] sub_w(logic [31:0] v);
    return {sbox_t[v[31:24]], sbox_t[v[23:16]],
            sbox_t[v[15:8]], sbox_t[v[7:0]]};
  endfunction

  function automatic logic [7:0] rc(int n);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 1; k < n; k++) r = gf_mul(r, 8'h02);
    return r;
  endfunction

  function automatic int nk_g(int g);
    return 4 + 2 * g;
  endfunction

  task automatic expand(int g, logic [255:0] key);
    int nk;
    int nw;
    logic [31:0] t;
    nk = nk_g(g);
    nw = 4 * (nk + 7);
    for (int j = 0; j < nk; j++)
      ref_w[g][j] = key[32*nk-1-32*j -: 32];
    for (int j = nk; j < nw; j++) begin
      t = ref_w[g][j-1];
      if (j % nk == 0)
        t = sub_w({t[23:0], t[31:24]}) ^ {rc(j / nk), 24'h0};
      else if (nk == 8 && j % nk == 4)
        t = sub_w(t);
      ref_w[g][j] = ref_w[g][j-nk] ^ t;
    end
  endtask

  function automatic logic [130:0] model_exp(int g, int r);
    if (r > nk_g(g) + 6) return {2'(g), 1'b1, 128'h0};
    return {2'(g), 1'b0, ref_w[g][4*r], ref_w[g][4*r+1],
            ref_w[g][4*r+2], ref_w[g][4*r+3]};
  endfunction

  function automatic logic [255:0] rand_key(int g);
    logic [255:0] k;
    for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom;
    return k & ((256'h1 << (128 + 64 * g)) - 256'h1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(int g);
    check_b("rst_key_ready", key_ready[g], 1'b1);
    check_b("rst_sched_valid", sched_valid[g], 1'b0);
    check_b("rst_rk_valid", rk_out_valid[g], 1'b0);
    check_b("rst_rd_err", rk_rd_err[g], 1'b0);
    check("rst_rk_out", 256'(rk_out[g]), 256'h0);
  endtask

  task automatic start_key(int g, logic [255:0] key);
    check_b("key_ready_before", key_ready[g], 1'b1);
    key_in[g] = key;
    key_valid[g] = 1'b1;
    step();
    key_valid[g] = 1'b0;
    mready[g] = 1'b0;
    expand(g, key);
    check_b("sched_drop", sched_valid[g], 1'b0);
    check_b("key_ready_busy", key_ready[g], 1'b0);
  endtask

  task automatic wait_sched(int g, int already);
    int cnt;
    cnt = already;
    while (!sched_valid[g] && cnt < 200) begin
      step();
      cnt++;
    end
    check("sched_edge", 256'(cnt), 256'(4 * (nk_g(g) + 7) - nk_g(g)));
    mready[g] = sched_valid[g];
  endtask

  task automatic read(int g, int r);
    rk_rd_idx[g] = 4'(r);
    rk_rd_en[g] = 1'b1;
    if (mready[g]) sb.push_back(model_exp(g, r));
    step();
    rk_rd_en[g] = 1'b0;
  endtask

  task automatic read_lit(int g, int r, logic [127:0] v);
    rk_rd_idx[g] = 4'(r);
    rk_rd_en[g] = 1'b1;
    sb.push_back({2'(g), 1'b0, v});
    step();
    rk_rd_en[g] = 1'b0;
  endtask

  task automatic sweep(int g);
    for (int r = 0; r <= nk_g(g) + 7; r++) read(g, r);
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (rk_out_valid[g]) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_read: dut %0d got %h none queued",
                   g, rk_out[g]);
        end else begin
          check("rk_read", 256'({2'(g), rk_rd_err[g], rk_out[g]}),
                256'(sb.pop_front()));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1);
  end

  localparam logic [255:0] K128 =
    256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] K192 =
    256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  initial begin
    logic [255:0] knew;
    int g;
    rst_n = 1'b0;
    key_valid = '0;
    rk_rd_en = '0;
    mready = '0;
`ifdef KEY_EXP_ZEROIZE_EN
    zeroize = '0;
`endif
    for (int k = 0; k < 3; k++) begin
      key_in[k] = '0;
      rk_rd_idx[k] = '0;
    end
    build_sbox();
    #12;
    for (int k = 0; k < 3; k++) check_reset(k);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Known answers, 128/192/256.
    start_key(0, K128);
    wait_sched(0, 0);
    read_lit(0, 1, 128'ha0fafe1788542cb123a339392a6c7605);
    read_lit(0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    sweep(0);
    step();
    check_b("err_one_cycle", rk_rd_err[0], 1'b0);
    check_b("valid_drop", rk_out_valid[0], 1'b0);
    check("rk_hold", 256'(rk_out[0]), 256'h0);

    start_key(1, K192);
    wait_sched(1, 0);
    read_lit(1, 12, 128'he98ba06f448c773c8ecc720401002202);
    sweep(1);

    start_key(2, K256);
    wait_sched(2, 0);
    read_lit(2, 14, 128'hfe4890d1e6188d0b046df344706c631e);
    sweep(2);

    // Second key and a read during EXPAND are both ignored.
    start_key(0, rand_key(0));
    key_in[0] = rand_key(0);
    key_valid[0] = 1'b1;
    rk_rd_idx[0] = 4'd2;
    rk_rd_en[0] = 1'b1;
    step();
    check_b("key_ready_expand", key_ready[0], 1'b0);
    check_b("read_in_expand", rk_out_valid[0], 1'b0);
    repeat (3) step();
    key_valid[0] = 1'b0;
    rk_rd_en[0] = 1'b0;
    wait_sched(0, 4);
    sweep(0);

    // Reload in READY: a same-edge read sees the old schedule.
    rk_rd_idx[1] = 4'd3;
    rk_rd_en[1] = 1'b1;
    sb.push_back(model_exp(1, 3));
    knew = rand_key(1);
    key_in[1] = knew;
    key_valid[1] = 1'b1;
    step();
    key_valid[1] = 1'b0;
    rk_rd_en[1] = 1'b0;
    mready[1] = 1'b0;
    expand(1, knew);
    check_b("sched_drop_reload", sched_valid[1], 1'b0);
    wait_sched(1, 0);
    sweep(1);

    // Async reset mid-expansion, then the same key again.
    start_key(0, K128);
    repeat (20) step();
    rst_n = 1'b0;
    #1;
    check_reset(0);
    mready = '0;
    #2;
    rst_n = 1'b1;
    step();

    // Key load and read on the same IDLE edge: read ignored.
    rk_rd_idx[0] = 4'd1;
    rk_rd_en[0] = 1'b1;
    start_key(0, K128);
    rk_rd_en[0] = 1'b0;
    check_b("read_on_idle_load", rk_out_valid[0], 1'b0);
    wait_sched(0, 0);
    read_lit(0, 1, 128'ha0fafe1788542cb123a339392a6c7605);
    read_lit(0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    for (int it = 0; it < 6; it++) begin
      g = int'($urandom_range(0, 2));
      if (!key_ready[g]) wait_sched(g, 0);
      start_key(g, rand_key(g));
      wait_sched(g, 0);
      for (int r = 0; r < 8; r++) read(g, int'($urandom_range(0, 15)));
    end

`ifdef KEY_EXP_ZEROIZE_EN
    // Zeroize in READY with an in-flight read.
    start_key(0, rand_key(0));
    wait_sched(0, 0);
    rk_rd_idx[0] = 4'd5;
    rk_rd_en[0] = 1'b1;
    sb.push_back(model_exp(0, 5));
    zeroize[0] = 1'b1;
    step();
    zeroize[0] = 1'b0;
    rk_rd_en[0] = 1'b0;
    mready[0] = 1'b0;
    check_b("zero_sched", sched_valid[0], 1'b0);
    check_b("zero_key_ready", key_ready[0], 1'b0);
    repeat (9) step();
    check_b("zero_busy_e10", key_ready[0], 1'b0);
    step();
    check_b("zero_done_e11", key_ready[0], 1'b1);
    start_key(0, rand_key(0));
    wait_sched(0, 0);
    sweep(0);
`endif

    repeat (3) step();
    check("sb_drain", 256'(sb.size()), 256'h0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
